// File: rtl/sar_search_16bit.sv
// Successive-approximation search engine: drives a probe into a magnitude comparator and
// binary-searches the comparator's A-side target from the gt/eq/lt flags it returns.
module sar_search_16bit #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     cmp_gt,
  input  logic                     cmp_eq,
  input  logic                     cmp_lt,
  output logic [WIDTH-1:0]         probe,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic                     err,
  output logic [WIDTH-1:0]         result,
  output logic [$clog2(WIDTH):0]   iters
);

  // state  | meaning
  // IDLE   | waiting for start; outputs of the last search hold
  // SEARCH | one comparison consumed per clock edge
  typedef enum logic {IDLE, SEARCH} state_t;

  localparam logic [WIDTH:0] RANGE_MAX   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH:0] ONE_X       = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] FIRST_MID = {1'b0, {(WIDTH-1){1'b1}}};

  state_t                 state_q;
  logic [WIDTH:0]         lo_q, hi_q;
  logic [WIDTH-1:0]       probe_q, result_q;
  logic [$clog2(WIDTH):0] iters_q;
  logic                   busy_q, done_q, found_q, err_q;

  logic [WIDTH:0] probe_x, lo_inc, hi_dec, mid_gt, mid_lt, mid_d;
  logic           flags_ok, gt_empty, lt_empty, empty_d;

  always_comb begin
    probe_x  = {1'b0, probe_q};
    lo_inc   = probe_x + ONE_X;
    hi_dec   = probe_x - ONE_X;
    mid_gt   = lo_inc + ((hi_q - lo_inc) >> 1);
    mid_lt   = lo_q + ((hi_dec - lo_q) >> 1);
    flags_ok = $onehot({cmp_gt, cmp_eq, cmp_lt});
    gt_empty = lo_inc > hi_q;
    lt_empty = (probe_q == '0) || (lo_q > hi_dec);
    mid_d    = cmp_gt ? mid_gt : mid_lt;
    // A mid above the WIDTH-bit range can only come from a range that is already empty.
    empty_d  = (cmp_gt ? gt_empty : lt_empty) | mid_d[WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      iters_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            lo_q    <= '0;
            hi_q    <= RANGE_MAX;
            probe_q <= FIRST_MID;
            iters_q <= '0;
            found_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= SEARCH;
          end
        end
        SEARCH: begin
          iters_q <= iters_q + 1'b1;
          if (!flags_ok) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (cmp_eq) begin
            result_q <= probe_q;
            found_q  <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end else begin
            if (cmp_gt) lo_q <= lo_inc;
            else        hi_q <= hi_dec;
            if (empty_d) begin
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              probe_q <= mid_d[WIDTH-1:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign iters  = iters_q;

endmodule

// File: tb/tb_sar_search_16bit.sv
// Bench for sar_search_16bit: a behavioural comparator plus an integer binary-search
// reference model predict every search outcome.
module tb_sar_search_16bit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic        cmp_gt, cmp_eq, cmp_lt;
  logic [15:0] probe, result;
  logic        busy, done, found, err;
  logic [4:0]  iters;

  int target;
  int mode;     // 0 real comparator, 1 gt stuck, 2 no flags, 3 gt+lt together
  int n_checks = 0;
  int n_errors = 0;

  sar_search_16bit #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt),
    .probe(probe), .busy(busy), .done(done), .found(found),
    .err(err), .result(result), .iters(iters)
  );

  always #5 clk = ~clk;

  always_comb begin
    cmp_gt = 1'b0; cmp_eq = 1'b0; cmp_lt = 1'b0;
    case (mode)
      0: begin
        cmp_gt = target > int'(probe);
        cmp_eq = target == int'(probe);
        cmp_lt = target < int'(probe);
      end
      1: cmp_gt = 1'b1;
      3: begin cmp_gt = 1'b1; cmp_lt = 1'b1; end
      default: ;
    endcase
  end

  // Reference: plain integer binary search over [0, 65535] following the flag rules.
  function automatic void ref_search(input int md, input int tgt, output int it,
                                     output bit fnd, output bit er, output int res,
                                     output int last_probe);
    int lo, hi, p, ngt, neq, nlt;
    lo = 0; hi = 65535; p = 32767;
    it = 0; fnd = 0; er = 0; res = 0;
    while (it < 100) begin
      it++;
      ngt = 0; neq = 0; nlt = 0;
      if (md == 0) begin ngt = int'(tgt > p); neq = int'(tgt == p); nlt = int'(tgt < p); end
      else if (md == 1) ngt = 1;
      else if (md == 3) begin ngt = 1; nlt = 1; end
      if (ngt + neq + nlt != 1) begin er = 1; break; end
      if (neq == 1) begin fnd = 1; res = p; break; end
      if (ngt == 1) lo = p + 1; else hi = p - 1;
      if (lo > hi) begin er = 1; break; end
      p = lo + (hi - lo) / 2;
    end
    last_probe = p;
  endfunction

  // Stimulus only: launches a search and reports what the DUT did.
  task automatic do_search(input int tgt, input int md, input int pulse_at,
                           output bit busy0, output int probe0, output bit seen,
                           output int edges, output bit done_after);
    target = tgt; mode = md;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy; probe0 = int'(probe);
    edges = 0; seen = 0;
    while (edges < 40 && !seen) begin
      if (edges == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (done) seen = 1;
    end
    @(posedge clk); #1;
    done_after = done;
  endtask

  task automatic test_reset;
    n_checks++; if (probe !== 16'd0) begin n_errors++; $display("FAIL reset_probe: got %0d want 0", probe); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_errors++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    n_checks++; if (found !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL reset_found_err: got %b%b want 00", found, err); end
    n_checks++; if (result !== 16'd0 || iters !== 5'd0) begin n_errors++; $display("FAIL reset_result_iters: got %0d/%0d want 0/0", result, iters); end
  endtask

  task automatic test_target(input int tgt, input int md, input string name);
    bit busy0, seen, done_after, efnd, eerr;
    int probe0, edges, eit, eres, eprobe;
    ref_search(md, tgt, eit, efnd, eerr, eres, eprobe);
    do_search(tgt, md, -1, busy0, probe0, seen, edges, done_after);
    n_checks++; if (busy0 !== 1'b1 || probe0 != 32767) begin n_errors++; $display("FAIL %s_launch: busy %b probe %0d want 1 32767", name, busy0, probe0); end
    n_checks++; if (!seen || edges != eit) begin n_errors++; $display("FAIL %s_latency: done %b after %0d edges want %0d", name, seen, edges, eit); end
    n_checks++; if (found !== efnd || err !== eerr) begin n_errors++; $display("FAIL %s_status: found %b err %b want %b %b", name, found, err, efnd, eerr); end
    n_checks++; if (int'(iters) != eit) begin n_errors++; $display("FAIL %s_iters: got %0d want %0d", name, iters, eit); end
    n_checks++; if (int'(probe) != eprobe) begin n_errors++; $display("FAIL %s_probe: got %0d want %0d", name, probe, eprobe); end
    if (efnd) begin
      n_checks++; if (int'(result) != eres) begin n_errors++; $display("FAIL %s_result: got %0d want %0d", name, result, eres); end
    end
    n_checks++; if (done_after !== 1'b0 || busy !== 1'b0) begin n_errors++; $display("FAIL %s_pulse: done %b busy %b after end want 0 0", name, done_after, busy); end
  endtask

  task automatic test_directed;
    int it; bit f, e; int r, lp;
    test_target(25, 0, "t25");
    test_target(32767, 0, "t32767");
    n_checks++; if (iters !== 5'd1) begin n_errors++; $display("FAIL first_probe_iters: got %0d want 1", iters); end
    test_target(0, 0, "t0");
    test_target(65535, 0, "t65535");
    ref_search(0, 65535, it, f, e, r, lp);
    n_checks++; if (int'(iters) > 17 || int'(iters) != it) begin n_errors++; $display("FAIL t65535_bound: got %0d want %0d", iters, it); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 24; i++) test_target(int'($urandom_range(65535, 0)), 0, "rand");
  endtask

  task automatic test_faults;
    test_target(123, 1, "stuck_gt");
    n_checks++; if (probe !== 16'hFFFF || err !== 1'b1 || found !== 1'b0) begin n_errors++; $display("FAIL stuck_gt_end: probe %0d err %b found %b want 65535 1 0", probe, err, found); end
    test_target(123, 2, "no_flags");
    n_checks++; if (iters !== 5'd1) begin n_errors++; $display("FAIL no_flags_iters: got %0d want 1", iters); end
    test_target(123, 3, "multi_flags");
  endtask

  task automatic test_idle_hold;
    logic [15:0] r0, p0; logic [4:0] i0; logic f0;
    test_target(777, 0, "hold");
    r0 = result; p0 = probe; i0 = iters; f0 = found;
    repeat (6) @(posedge clk);
    #1;
    n_checks++; if (result !== r0 || probe !== p0 || iters !== i0 || found !== f0 || result !== 16'd777) begin
      n_errors++; $display("FAIL idle_hold: result %0d probe %0d iters %0d found %b want %0d %0d %0d %b", result, probe, iters, found, 777, p0, i0, f0);
    end
  endtask

  task automatic test_start_while_busy;
    bit busy0, seen, done_after, efnd, eerr;
    int probe0, edges, eit, eres, eprobe;
    ref_search(0, 50, eit, efnd, eerr, eres, eprobe);
    do_search(50, 0, 3, busy0, probe0, seen, edges, done_after);
    n_checks++; if (!seen || edges != eit || int'(iters) != eit) begin n_errors++; $display("FAIL busy_start_latency: edges %0d iters %0d want %0d", edges, iters, eit); end
    n_checks++; if (result !== 16'd50 || found !== 1'b1 || err !== 1'b0) begin n_errors++; $display("FAIL busy_start_result: got %0d found %b err %b want 50 1 0", result, found, err); end
  endtask

  task automatic test_reset_mid;
    int dones;
    target = 40000; mode = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || probe !== 16'd0 || done !== 1'b0) begin n_errors++; $display("FAIL midrst_outputs: busy %b probe %0d done %b want 0 0 0", busy, probe, done); end
    n_checks++; if (iters !== 5'd0 || found !== 1'b0 || err !== 1'b0) begin n_errors++; $display("FAIL midrst_status: iters %0d found %b err %b want 0 0 0", iters, found, err); end
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    n_checks++; if (dones != 0) begin n_errors++; $display("FAIL midrst_no_done: got %0d pulses want 0", dones); end
    test_target(40000, 0, "t40000");
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; target = 0; mode = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    rst = 1'b0;
    @(posedge clk); #1;
    test_directed;
    test_random;
    test_faults;
    test_idle_hold;
    test_start_while_busy;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
